rx_descrambler: RTL
===================

// Module: rx_descrambler
// PURPOSE
//  Receive-side Gen1/Gen2 (8b/10b) descrambler for the PIPE lane; mirror of the TX scrambler.
//  Sits between the RX symbol/elastic-buffer path and the link layer.
//  Removes the x^16+x^5+x^4+x^3+1 scrambling from data bytes, re-synchronises its LFSR on COM,
//  freezes it on SKP, and reports lock. Handles 8/16/32-bit PIPE widths (1/2/4 bytes per pclk).
// PARAMETERS
//  SEED          16'hFFFF  LFSR value loaded on COM, on reset and on turnOff
//  COM_SYM       8'hBC     K28.5: resets LFSR (takes effect from the following byte)
//  SKP_SYM       8'h1C     K28.0: LFSR does not advance
//  LOCK_TIMEOUT  4096      max bytes between COMs before lock is lost (DESCR_LOCK_LOSS_EN only)
// PORTS
//  pclk                  in   1   PIPE clock; all state on rising edge
//  reset_n               in   1   synchronous, active-low reset
//  turnOff               in   1   1 = scrambling disabled: registered pass-through
//  PIPEWIDTH             in   6   8/16/32 = active bytes 1/2/4; any other value = invalid
//  rxDataIn              in   32  received symbols, byte 0 = [7:0] = earliest in time
//  rxDataKIn             in   4   per-byte K flag (1 = control symbol)
//  rxDataValidIn         in   1   word qualifier
//  descramblerDataOut    out  32  descrambled symbols; inactive bytes driven 0
//  descramblerDataK      out  4   rxDataKIn delayed 1 cycle
//  descramblerDataValid  out  1   rxDataValidIn delayed 1 cycle
//  descramblerLocked     out  1   1 = LFSR aligned to a received COM
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): all outputs 0, LFSR=SEED, FSM=UNLOCKED, byte counter 0.
//  - Latency: exactly 1 pclk from inputs to all outputs (registered).
//  - Bytes processed in order 0..N-1 within a word; LFSR state seen by byte i includes
//    the effect of bytes 0..i-1 of the same word.
//  - Per byte, by class:
//    COM (K=1, 0xBC): passed unchanged; LFSR := SEED for next byte; FSM -> LOCKED.
//    SKP (K=1, 0x1C): passed unchanged; LFSR holds.
//    other K: passed unchanged; LFSR advances 8 shifts.
//    D (K=0): out = in ^ key; LFSR advances 8 shifts. key bit j = lfsr[15] before shift j,
//    j=0..7, XORed onto data bit j; Galois shift, feedback taps 5,4,3,0.
//  - FSM UNLOCKED: D bytes passed raw (no XOR), LFSR still advances; first COM -> LOCKED,
//    later bytes of same word descrambled. LOCKED: descramble as above.
//  - descramblerLocked is the FSM state after the last byte of the word; updates with data.
//  - rxDataValidIn=0: LFSR, FSM, counter hold; data/K still registered, valid out 0.
//  - turnOff=1: out = rxDataIn unmasked, LFSR := SEED, FSM := UNLOCKED, counter 0;
//    deassertion resumes UNLOCKED, waiting for COM.
//  - Invalid PIPEWIDTH with turnOff=0: data out 0, K/valid still forwarded, state holds.
//  - Bytes above active width: ignored for state, output 0.
// CONFIGURATION
//  DESCR_LOCK_LOSS_EN defined: counter of valid bytes since last COM, saturating at
//    LOCK_TIMEOUT; on reaching it FSM -> UNLOCKED (effective from next word), LFSR not reseeded.
//    Any COM clears the counter.
//  Not defined: no counter; LOCKED persists until reset_n or turnOff.
// STRUCTURE
//  Package pipe_rx_pkg: COM_SYM/SKP_SYM defaults, PIPEWIDTH encodings (8/16/32),
//    FSM state enum {UNLOCKED, LOCKED}, function lfsr_adv8(state) -> {next, key}.
//  Sub-module descr_byte_lane (combinational): one byte + K + lfsr_in + locked_in ->
//    byte out, lfsr_out, com_seen; 4 instances chained; output mux selects by PIPEWIDTH.
// TESTING
//  1 W=8: COM then 8 D bytes of 0xFF,0x17,0xC0,0x14,0xB2,0xE7,0x02,0x82 -> out 0x00 x8,
//    locked=1 one cycle after COM.
//  2 W=32: word {D,D,SKP,COM} then scrambled zeros -> SKP byte out 0x1C, no LFSR advance;
//    next word bytes 0x00.
//  3 W=16: D bytes before any COM -> passed raw, locked=0; COM in byte 1 -> locked=1 next cycle.
//  4 valid=0 for 3 cycles mid-stream, then resume -> descrambled stream continuous; 0x00 retained.
//  5 turnOff=1 mid-stream -> raw pass-through, locked=0; release -> re-lock on next COM only.
//  6 DESCR_LOCK_LOSS_EN, LOCK_TIMEOUT=16, W=8: 16 D bytes with no COM -> locked falls;
//    PIPEWIDTH=12 -> data out 0.

Source files
------------

// File: rtl/pipe_rx_pkg.sv
// Shared definitions for the PIPE RX descrambler: symbol codes, PIPEWIDTH encodings,
// lock FSM states and the 8-shift Galois LFSR step (x^16+x^5+x^4+x^3+1).
package pipe_rx_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = LANES * BYTE_W;
  localparam int unsigned PW_W   = 6;

  localparam logic [LFSR_W-1:0] SEED_DEF    = 16'hFFFF;
  localparam logic [BYTE_W-1:0] COM_SYM_DEF = 8'hBC;
  localparam logic [BYTE_W-1:0] SKP_SYM_DEF = 8'h1C;
  localparam logic [LFSR_W-1:0] LFSR_TAPS   = 16'h0039;

  localparam logic [PW_W-1:0] PW_8  = 6'd8;
  localparam logic [PW_W-1:0] PW_16 = 6'd16;
  localparam logic [PW_W-1:0] PW_32 = 6'd32;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } descr_state_e;

  typedef struct packed {
    logic [LFSR_W-1:0] nxt;
    logic [BYTE_W-1:0] key;
  } lfsr_step_t;

  // Key bit j is the MSB before shift j; the MSB is fed back onto taps 5,4,3,0.
  function automatic lfsr_step_t lfsr_adv8(input logic [LFSR_W-1:0] state);
    lfsr_step_t        res;
    logic [LFSR_W-1:0] s;
    s       = state;
    res.key = '0;
    for (int j = 0; j < int'(BYTE_W); j++) begin
      res.key[j] = s[LFSR_W-1];
      s = {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? LFSR_TAPS : '0);
    end
    res.nxt = s;
    return res;
  endfunction

endpackage

// File: rtl/descr_byte_lane.sv
// One byte slot of the descrambler: classifies the symbol, descrambles data bytes
// when locked, and hands the updated LFSR to the next (later-in-time) byte.
module descr_byte_lane
  import pipe_rx_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED    = SEED_DEF,
  parameter logic [BYTE_W-1:0] COM_SYM = COM_SYM_DEF,
  parameter logic [BYTE_W-1:0] SKP_SYM = SKP_SYM_DEF
) (
  input  logic              i_active,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_k,
  input  logic [LFSR_W-1:0] i_lfsr,
  input  logic              i_locked,
  output logic [BYTE_W-1:0] o_byte_c,
  output logic [LFSR_W-1:0] o_lfsr_c,
  output logic              o_com_c
);

  lfsr_step_t w_step;

  assign w_step = lfsr_adv8(i_lfsr);

  // Inactive bytes leave the LFSR untouched and output zero.
  always_comb begin
    o_byte_c = '0;
    o_lfsr_c = i_lfsr;
    o_com_c  = 1'b0;
    if (i_active) begin
      if (i_k && (i_byte == COM_SYM)) begin
        o_byte_c = i_byte;
        o_lfsr_c = SEED;
        o_com_c  = 1'b1;
      end else if (i_k && (i_byte == SKP_SYM)) begin
        o_byte_c = i_byte;
      end else begin
        o_byte_c = (!i_k && i_locked) ? (i_byte ^ w_step.key) : i_byte;
        o_lfsr_c = w_step.nxt;
      end
    end
  end

endmodule

// File: rtl/rx_descrambler.sv
// PIPE RX Gen1/Gen2 descrambler, 1/2/4 bytes per pclk, one-cycle registered latency.
// Optional DESCR_LOCK_LOSS_EN drops lock after LOCK_TIMEOUT valid bytes without a COM.
module rx_descrambler
  import pipe_rx_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED    = SEED_DEF,
  parameter logic [BYTE_W-1:0] COM_SYM = COM_SYM_DEF,
  parameter logic [BYTE_W-1:0] SKP_SYM = SKP_SYM_DEF
`ifdef DESCR_LOCK_LOSS_EN
  ,
  parameter int unsigned       LOCK_TIMEOUT = 4096
`endif
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              turnOff,
  input  logic [PW_W-1:0]   PIPEWIDTH,
  input  logic [DATA_W-1:0] rxDataIn,
  input  logic [LANES-1:0]  rxDataKIn,
  input  logic              rxDataValidIn,
  output logic [DATA_W-1:0] descramblerDataOut,
  output logic [LANES-1:0]  descramblerDataK,
  output logic              descramblerDataValid,
  output logic              descramblerLocked
);

  logic [DATA_W-1:0] r_data;
  logic [LANES-1:0]  r_k;
  logic              r_valid;
  logic              r_locked;
  logic [LFSR_W-1:0] r_lfsr;
  descr_state_e      r_state;

  logic [LANES-1:0]  w_active;
  logic              w_width_ok;
  logic [LFSR_W-1:0] w_lfsr [LANES+1];
  logic [LANES:0]    w_lock;
  logic [LANES-1:0]  w_com;
  logic [DATA_W-1:0] w_data;
  descr_state_e      w_state_nxt;

  always_comb begin
    w_active = '0;
    case (PIPEWIDTH)
      PW_8:    w_active = 4'b0001;
      PW_16:   w_active = 4'b0011;
      PW_32:   w_active = 4'b1111;
      default: w_active = '0;
    endcase
  end

  assign w_width_ok = (w_active != '0);
  assign w_lfsr[0]  = r_lfsr;
  assign w_lock[0]  = (r_state == LOCKED);

  // Byte 0 is earliest: each lane sees the LFSR and lock left by the bytes before it.
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    descr_byte_lane #(
      .SEED    (SEED),
      .COM_SYM (COM_SYM),
      .SKP_SYM (SKP_SYM)
    ) u_lane (
      .i_active (w_active[i]),
      .i_byte   (rxDataIn[i*BYTE_W +: BYTE_W]),
      .i_k      (rxDataKIn[i]),
      .i_lfsr   (w_lfsr[i]),
      .i_locked (w_lock[i]),
      .o_byte_c (w_data[i*BYTE_W +: BYTE_W]),
      .o_lfsr_c (w_lfsr[i+1]),
      .o_com_c  (w_com[i])
    );
    assign w_lock[i+1] = w_lock[i] | w_com[i];
  end

`ifdef DESCR_LOCK_LOSS_EN
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic             w_timeout;

  // Bytes since the last COM, saturating; timeout applies at the word boundary.
  always_comb begin
    w_cnt = r_cnt;
    for (int i = 0; i < int'(LANES); i++) begin
      if (w_active[i]) begin
        if (w_com[i]) begin
          w_cnt = '0;
        end else if (w_cnt != CNT_W'(LOCK_TIMEOUT)) begin
          w_cnt = w_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign w_timeout   = (w_cnt == CNT_W'(LOCK_TIMEOUT));
  assign w_state_nxt = (w_lock[LANES] && !w_timeout) ? LOCKED : UNLOCKED;

  always_ff @(posedge pclk) begin
    if (!reset_n || turnOff) begin
      r_cnt <= '0;
    end else if (w_width_ok && rxDataValidIn) begin
      r_cnt <= w_cnt;
    end
  end
`else
  assign w_state_nxt = w_lock[LANES] ? LOCKED : UNLOCKED;
`endif

  // Lock FSM, LFSR and output registers.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_k      <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_lfsr   <= SEED;
      r_state  <= UNLOCKED;
    end else begin
      r_k     <= rxDataKIn;
      r_valid <= rxDataValidIn;
      if (turnOff) begin
        r_data   <= rxDataIn;
        r_lfsr   <= SEED;
        r_state  <= UNLOCKED;
        r_locked <= 1'b0;
      end else if (!w_width_ok) begin
        r_data   <= '0;
        r_locked <= (r_state == LOCKED);
      end else begin
        r_data <= w_data;
        if (rxDataValidIn) begin
          r_lfsr   <= w_lfsr[LANES];
          r_state  <= w_state_nxt;
          r_locked <= (w_state_nxt == LOCKED);
        end else begin
          r_locked <= (r_state == LOCKED);
        end
      end
    end
  end

  assign descramblerDataOut   = r_data;
  assign descramblerDataK     = r_k;
  assign descramblerDataValid = r_valid;
  assign descramblerLocked    = r_locked;

endmodule
